// File: rtl/pio_edge_in.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture (write-1-to-clear), irq mask and edge mode.
// Optional per-bit debouncer between synchroniser and value register: define PIO_DEBOUNCE_EN.
module pio_edge_in #(
    parameter int         WIDTH           = 10,
    parameter logic [1:0] EDGE_RESET      = 2'b00,
    parameter int         DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

`ifdef PIO_DEBOUNCE_EN
    localparam logic [16:0] WARM    = 17'(3 + DEBOUNCE_CYCLES);
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
`else
    localparam logic [16:0] WARM    = 17'd3;
`endif

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_ECAP  = 2'd2;
    localparam logic [1:0] ADDR_EMODE = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [1:0]       edgemode_q, edgemode_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [16:0]      warm_q, warm_d;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] rise, fall, event_v, clear_mask;
    logic             wr_en, warm_done;
    logic             unused_ok;

    // Upper writedata bits and the debounce length are intentionally ignored in some builds.
    assign unused_ok = ^{writedata, 32'(DEBOUNCE_CYCLES)};

`ifdef PIO_DEBOUNCE_EN
    logic [WIDTH-1:0] val_q;
    logic [15:0]      db_cnt_q [WIDTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            val_q <= '0;
            for (int i = 0; i < WIDTH; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] == val_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    val_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign val = val_q;
`else
    assign val = sync2_q;
`endif

    assign wr_en     = chipselect & ~write_n;
    assign warm_done = (warm_q == WARM);
    assign rise      = val & ~prev_q;
    assign fall      = ~val & prev_q;

    always_comb begin
        event_v = '0;
        if (warm_done) begin
            case (edgemode_q)
                2'b00:   event_v = rise;
                2'b01:   event_v = fall;
                2'b10:   event_v = rise | fall;
                default: event_v = '0;
            endcase
        end
    end

    // A new event on the same cycle as a clear keeps the bit set.
    always_comb begin
        clear_mask = '0;
        irqmask_d  = irqmask_q;
        edgemode_d = edgemode_q;
        if (wr_en) begin
            case (address)
                ADDR_MASK:  irqmask_d  = writedata[WIDTH-1:0];
                ADDR_ECAP:  clear_mask = writedata[WIDTH-1:0];
                ADDR_EMODE: edgemode_d = writedata[1:0];
                default:    ;
            endcase
        end
        ecap_d = (ecap_q & ~clear_mask) | event_v;
        warm_d = warm_done ? warm_q : warm_q + 17'd1;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:  readdata_d[WIDTH-1:0] = val;
            ADDR_MASK:  readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_ECAP:  readdata_d[WIDTH-1:0] = ecap_q;
            ADDR_EMODE: readdata_d[1:0]       = edgemode_q;
            default:    readdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            ecap_q     <= '0;
            irqmask_q  <= '0;
            edgemode_q <= EDGE_RESET;
            readdata_q <= '0;
            warm_q     <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            prev_q     <= val;
            ecap_q     <= ecap_d;
            irqmask_q  <= irqmask_d;
            edgemode_q <= edgemode_d;
            readdata_q <= readdata_d;
            warm_q     <= warm_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(ecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_edge_in.sv
// Directed bench for pio_edge_in: register map, edge modes, set/clear race, irq masking, warm-up and reset.
module tb_pio_edge_in;
    localparam int W = 10;
`ifdef PIO_DEBOUNCE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 0;
`endif
    localparam int SETTLE = 5 + LAT;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic [1:0]    address    = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port    = '0;
    logic          irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_edge_in #(.WIDTH(W), .EDGE_RESET(2'b00), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cycle();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1;
        cycle();
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0; in_port = 10'h3FF;
        idle(3);
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h exp %h", readdata, 32'h0); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        reset_n = 1'b1;
        bus_write(2'd1, 32'h3FF);
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL warm_irq cyc %0d got %b exp 0", i, irq); end
        end
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL warm_ecap got %h exp %h", rd, 32'h0); end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'h3FF) begin errors++; $display("FAIL warm_data got %h exp %h", rd, 32'h3FF); end
        bus_read(2'd3, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_edgemode got %h exp %h", rd, 32'h0); end
    endtask

    task automatic test_rise();
        logic [31:0] rd;
        logic [31:0] exp;
        in_port = '0;
        idle(SETTLE);
        bus_write(2'd2, 32'h3FF);
        bus_write(2'd1, 32'h001);
        in_port = 10'h001;
        for (int i = 0; i <= LAT + 2; i++) begin
            bus_read(2'd0, rd);
            exp = (i >= LAT + 2) ? 32'h1 : 32'h0;
            checks++; if (rd !== exp) begin errors++; $display("FAIL rise_data edge %0d got %h exp %h", i, rd, exp); end
            checks++; if (irq !== exp[0]) begin errors++; $display("FAIL rise_irq edge %0d got %b exp %b", i, irq, exp[0]); end
        end
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h001) begin errors++; $display("FAIL rise_ecap got %h exp %h", rd, 32'h001); end
        bus_write(2'd2, 32'h001);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clear_irq got %b exp 0", irq); end
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clear_ecap got %h exp %h", rd, 32'h0); end
    endtask

    task automatic test_modes();
        logic [31:0] rd;
        bus_write(2'd3, 32'h1);
        in_port = 10'h009; idle(SETTLE);
        in_port = 10'h001; idle(SETTLE);
        in_port = 10'h009; idle(SETTLE);
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h008) begin errors++; $display("FAIL fall_only got %h exp %h", rd, 32'h008); end
        bus_read(2'd3, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL edgemode_rd1 got %h exp %h", rd, 32'h1); end
        bus_write(2'd2, 32'h3FF);
        bus_write(2'd3, 32'h2);
        in_port = 10'h001; idle(SETTLE);
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h008) begin errors++; $display("FAIL any_fall got %h exp %h", rd, 32'h008); end
        bus_write(2'd2, 32'h3FF);
        in_port = 10'h009; idle(SETTLE);
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h008) begin errors++; $display("FAIL any_rise got %h exp %h", rd, 32'h008); end
        bus_write(2'd2, 32'h3FF);
        bus_write(2'd3, 32'h3);
        in_port = 10'h000; idle(SETTLE);
        in_port = 10'h009; idle(SETTLE);
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL disabled_ecap got %h exp %h", rd, 32'h0); end
        bus_read(2'd3, rd);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL edgemode_rd3 got %h exp %h", rd, 32'h3); end
    endtask

    task automatic test_set_clear_same();
        logic [31:0] rd;
        bus_write(2'd3, 32'h0);
        in_port = 10'h000; idle(SETTLE);
        bus_write(2'd2, 32'h3FF);
        bus_write(2'd1, 32'h020);
        in_port = 10'h020; idle(SETTLE);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL bit5_irq got %b exp 1", irq); end
        in_port = 10'h000; idle(SETTLE);
        in_port = 10'h020; idle(LAT + 2);
        bus_write(2'd2, 32'h020);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL race_irq got %b exp 1", irq); end
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h020) begin errors++; $display("FAIL race_ecap got %h exp %h", rd, 32'h020); end
        bus_write(2'd2, 32'h020);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL race_clear_irq got %b exp 0", irq); end
    endtask

    task automatic test_irqmask();
        logic [31:0] rd;
        in_port = 10'h000; idle(SETTLE);
        bus_write(2'd2, 32'h3FF);
        bus_write(2'd1, 32'h0);
        in_port = 10'h3FF; idle(SETTLE);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq got %b exp 0", irq); end
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h3FF) begin errors++; $display("FAIL all_ecap got %h exp %h", rd, 32'h3FF); end
        bus_write(2'd1, 32'h200);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL unmask_irq got %b exp 1", irq); end
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h200) begin errors++; $display("FAIL mask_rd got %h exp %h", rd, 32'h200); end
        bus_write(2'd1, 32'hFFFF_FC00);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL upper_bits_irq got %b exp 0", irq); end
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL upper_bits_mask got %h exp %h", rd, 32'h0); end
        bus_write(2'd0, 32'h0);
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'h3FF) begin errors++; $display("FAIL data_write_ignored got %h exp %h", rd, 32'h3FF); end
        bus_write(2'd1, 32'h200);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        bus_write(2'd3, 32'h2);
        reset_n = 1'b0;
        cycle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got %b exp 0", irq); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL midreset_readdata got %h exp %h", readdata, 32'h0); end
        reset_n = 1'b1;
        bus_write(2'd1, 32'h3FF);
        idle(SETTLE + 5);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rewarm_irq got %b exp 0", irq); end
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rewarm_ecap got %h exp %h", rd, 32'h0); end
        bus_read(2'd3, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rewarm_edgemode got %h exp %h", rd, 32'h0); end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'h3FF) begin errors++; $display("FAIL rewarm_data got %h exp %h", rd, 32'h3FF); end
    endtask

`ifdef PIO_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] rd;
        in_port = 10'h000; idle(SETTLE);
        bus_write(2'd2, 32'h3FF);
        for (int i = 0; i < 10; i++) begin
            in_port[1] = ~in_port[1];
            bus_read(2'd0, rd);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bounce_data %0d got %h exp %h", i, rd, 32'h0); end
            cycle();
        end
        idle(SETTLE);
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bounce_ecap got %h exp %h", rd, 32'h0); end
        in_port = 10'h002;
        for (int i = 0; i < 6; i++) begin
            bus_read(2'd0, rd);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL hold_data_early %0d got %h exp %h", i, rd, 32'h0); end
        end
        in_port = 10'h000;
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'h002) begin errors++; $display("FAIL hold_data got %h exp %h", rd, 32'h002); end
        idle(SETTLE);
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h002) begin errors++; $display("FAIL hold_ecap got %h exp %h", rd, 32'h002); end
    endtask
`endif

    initial begin
        test_reset();
        test_rise();
        test_modes();
        test_set_clear_same();
        test_irqmask();
        test_reset_mid();
`ifdef PIO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
